// File: rtl/decoder_pkg.sv
// Shared mode and FSM encodings for the decoder_n_seq strobe sequencer.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_PULSE     = 2'b01,
    MODE_SCAN      = 2'b10,
    MODE_SCAN_LOOP = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_low_dec.sv
// Combinational index-to-active-low one-hot map; all ones when not valid.
module onehot_low_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      idx,
  input  logic                  valid,
  output logic [(2**SEL_W)-1:0] y_n
);

  always_comb begin
    y_n = '1;
    if (valid) y_n[idx] = 1'b0;
  end

endmodule

// File: rtl/decoder_n_seq.sv
// Registered N-to-2^N active-low decoder with timed pulse, one-shot scan and looping scan.
module decoder_n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  start,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] y_n,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  busy,
  output logic                  done
);

  localparam int OUT_N = 2**SEL_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_N - 1);

  state_t               state, state_nx;
  mode_t                cfg_mode, cfg_mode_nx;
  logic [DWELL_W-1:0]   cfg_reload, cfg_reload_nx;
  logic [DWELL_W-1:0]   cnt, cnt_nx;
  logic [SEL_W-1:0]     idx, idx_nx;
  logic                 out_valid;
  logic                 done_nx;
  logic [OUT_N-1:0]     y_n_nx;
  logic [DWELL_W-1:0]   start_reload;

  // A dwell of zero behaves as one; the counter holds D-1 down to 0.
  assign start_reload = (dwell == '0) ? '0 : dwell - 1'b1;

  always_comb begin
    state_nx      = state;
    cfg_mode_nx   = cfg_mode;
    cfg_reload_nx = cfg_reload;
    cnt_nx        = cnt;
    idx_nx        = idx;
    out_valid     = 1'b0;
    done_nx       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (en && start && (mode != MODE_DIRECT)) begin
          state_nx      = ST_ACTIVE;
          cfg_mode_nx   = mode_t'(mode);
          cfg_reload_nx = start_reload;
          cnt_nx        = start_reload;
          idx_nx        = (mode == MODE_PULSE) ? sel : '0;
          out_valid     = 1'b1;
        end else if (en && (mode == MODE_DIRECT)) begin
          idx_nx    = sel;
          out_valid = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (!en) begin
          state_nx = ST_IDLE;
        end else if (cnt != '0) begin
          cnt_nx    = cnt - 1'b1;
          out_valid = 1'b1;
        end else if ((cfg_mode == MODE_PULSE) ||
                     ((cfg_mode == MODE_SCAN) && (idx == LAST_IDX))) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else begin
          // Handover: next index falls on the same edge the current one rises.
          idx_nx    = idx + 1'b1;
          cnt_nx    = cfg_reload;
          out_valid = 1'b1;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  onehot_low_dec #(.SEL_W(SEL_W)) u_dec (
    .idx   (idx_nx),
    .valid (out_valid),
    .y_n   (y_n_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cfg_mode   <= MODE_DIRECT;
      cfg_reload <= '0;
      cnt        <= '0;
      idx        <= '0;
      y_n        <= '1;
      cur_sel    <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      cfg_mode   <= cfg_mode_nx;
      cfg_reload <= cfg_reload_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      y_n        <= y_n_nx;
      cur_sel    <= out_valid ? idx_nx : '0;
      done       <= done_nx;
    end
  end

  assign busy = (state == ST_ACTIVE);

endmodule

// File: tb/tb_decoder_n_seq.sv
// Directed self-checking bench for decoder_n_seq: reset, direct decode, pulse, scan, loop, abort, reset mid-scan.
module tb_decoder_n_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] sel;
  logic       start;
  logic [7:0] dwell;
  logic [7:0] y_n;
  logic [2:0] cur_sel;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  decoder_n_seq dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .sel     (sel),
    .start   (start),
    .dwell   (dwell),
    .y_n     (y_n),
    .cur_sel (cur_sel),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b10; sel = 3'd6; start = 1'b1; dwell = 8'd4;
    tick(); tick();
    total++;
    if (y_n !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || cur_sel !== 3'd0) begin
      bad++;
      $display("[TB] FAIL reset: y_n=%h busy=%b done=%b cur_sel=%0d, want FF 0 0 0", y_n, busy, done, cur_sel);
    end
    rst = 1'b0; start = 1'b0; mode = 2'b00; en = 1'b0;
    tick();
  endtask

  task automatic test_direct();
    logic [7:0] exp_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    en = 1'b1; mode = 2'b00; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick();
      total++;
      if (y_n !== exp_tab[i] || cur_sel !== 3'(i) || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL direct sel=%0d: y_n=%h cur_sel=%0d busy=%b, want %h %0d 0", i, y_n, cur_sel, busy, exp_tab[i], i);
      end
    end
    start = 1'b0;
    en = 1'b0;
    tick();
    total++;
    if (y_n !== 8'hFF || cur_sel !== 3'd0) begin
      bad++;
      $display("[TB] FAIL direct en=0: y_n=%h cur_sel=%0d, want FF 0", y_n, cur_sel);
    end
  endtask

  task automatic test_pulse();
    en = 1'b1; mode = 2'b01; sel = 3'd5; dwell = 8'd3; start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      // Disturb the inputs while busy; a second start must not restart.
      start = (c == 0);
      mode = 2'b10; sel = 3'd1; dwell = 8'd9;
      total++;
      if (y_n !== 8'hDF || busy !== 1'b1 || done !== 1'b0 || cur_sel !== 3'd5) begin
        bad++;
        $display("[TB] FAIL pulse active c=%0d: y_n=%h busy=%b done=%b cur_sel=%0d, want DF 1 0 5", c, y_n, busy, done, cur_sel);
      end
    end
    start = 1'b0; mode = 2'b01;
    tick();
    total++;
    if (y_n !== 8'hFF || busy !== 1'b0 || done !== 1'b1 || cur_sel !== 3'd0) begin
      bad++;
      $display("[TB] FAIL pulse end: y_n=%h busy=%b done=%b cur_sel=%0d, want FF 0 1 0", y_n, busy, done, cur_sel);
    end
    tick();
    total++;
    if (y_n !== 8'hFF || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pulse after: y_n=%h done=%b, want FF 0", y_n, done);
    end
  endtask

  task automatic test_scan();
    logic [7:0] exp_y;
    en = 1'b1; mode = 2'b10; sel = 3'd4; dwell = 8'd0; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
      exp_y = ~(8'd1 << i);
      total++;
      if (y_n !== exp_y || cur_sel !== 3'(i) || busy !== 1'b1 || done !== 1'b0 || $countones(~y_n) > 1) begin
        bad++;
        $display("[TB] FAIL scan step %0d: y_n=%h cur_sel=%0d busy=%b done=%b, want %h %0d 1 0", i, y_n, cur_sel, busy, done, exp_y, i);
      end
    end
    tick();
    total++;
    if (y_n !== 8'hFF || busy !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL scan end: y_n=%h busy=%b done=%b, want FF 0 1", y_n, busy, done);
    end
    tick();
  endtask

  task automatic test_scan_loop_abort();
    logic [7:0] exp_y;
    int         exp_i;
    en = 1'b1; mode = 2'b11; sel = 3'd0; dwell = 8'd2; start = 1'b1;
    for (int s = 0; s < 17; s++) begin
      tick();
      start = 1'b0;
      exp_i = (s / 2) % 8;
      exp_y = ~(8'd1 << exp_i);
      total++;
      if (y_n !== exp_y || cur_sel !== 3'(exp_i) || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL loop sample %0d: y_n=%h cur_sel=%0d busy=%b done=%b, want %h %0d 1 0", s, y_n, cur_sel, busy, done, exp_y, exp_i);
      end
    end
    en = 1'b0;
    tick();
    total++;
    if (y_n !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || cur_sel !== 3'd0) begin
      bad++;
      $display("[TB] FAIL loop abort: y_n=%h busy=%b done=%b cur_sel=%0d, want FF 0 0 0", y_n, busy, done, cur_sel);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL loop abort after: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_scan();
    en = 1'b1; mode = 2'b10; sel = 3'd0; dwell = 8'd1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0;
    end
    total++;
    if (cur_sel !== 3'd3 || y_n !== 8'hF7) begin
      bad++;
      $display("[TB] FAIL rst prep: y_n=%h cur_sel=%0d, want F7 3", y_n, cur_sel);
    end
    rst = 1'b1;
    tick();
    total++;
    if (y_n !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || cur_sel !== 3'd0) begin
      bad++;
      $display("[TB] FAIL rst mid-scan: y_n=%h busy=%b done=%b cur_sel=%0d, want FF 0 0 0", y_n, busy, done, cur_sel);
    end
    rst = 1'b0; mode = 2'b01; sel = 3'd2; dwell = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (y_n !== 8'hFB || busy !== 1'b1 || cur_sel !== 3'd2) begin
      bad++;
      $display("[TB] FAIL post-rst pulse: y_n=%h busy=%b cur_sel=%0d, want FB 1 2", y_n, busy, cur_sel);
    end
    tick();
    total++;
    if (y_n !== 8'hFF || busy !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL post-rst pulse end: y_n=%h busy=%b done=%b, want FF 0 1", y_n, busy, done);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; sel = '0; start = 1'b0; dwell = '0;
    #2;
    test_reset();
    test_direct();
    test_pulse();
    test_scan();
    test_scan_loop_abort();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
